// File: rtl/confreg_pkg.sv
// Shared register map, CTRL bit positions, reset constants and the byte-lane merge
// helper used by the confreg_resp peripheral window.
package confreg_pkg;

  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_CMP     = 16'hE004;
  localparam logic [15:0] OFF_CTRL    = 16'hE008;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_NUM     = 16'hF020;
  localparam logic [15:0] OFF_SWITCH  = 16'hF02C;
  localparam logic [15:0] OFF_UART_TX = 16'hF100;
  localparam logic [15:0] OFF_UART_ST = 16'hF104;
  localparam logic [15:0] OFF_SIMU    = 16'hFFF0;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_PEND   = 2;

  localparam logic [31:0] TIMER_RST = 32'h0000_0000;
  localparam logic [31:0] CMP_RST   = 32'hFFFF_FFFF;

  // Replace only the bytes whose write-enable bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/confreg_timer.sv
// Free-running compare timer with CMP/CTRL registers; raises a sticky pending flag on
// match and drives the interrupt level from registered state only.
module confreg_timer
  import confreg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_timer,
  input  logic        i_wr_cmp,
  input  logic        i_wr_ctrl,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_timer,
  output logic [31:0] o_cmp,
  output logic [2:0]  o_ctrl,
  output logic        o_irq
);

  logic [31:0] r_timer;
  logic [31:0] r_cmp;
  logic        r_run;
  logic        r_irq_en;
  logic        r_pend;
  logic        w_hit;
  logic        w_clr;

  assign w_hit = r_run && (r_timer == r_cmp);
  assign w_clr = i_wr_ctrl && i_wen[0] && i_wdata[CTRL_PEND];

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer  <= TIMER_RST;
      r_cmp    <= CMP_RST;
      r_run    <= 1'b0;
      r_irq_en <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (i_wr_timer)  r_timer <= lane_merge(r_timer, i_wdata, i_wen);
      else if (r_run)  r_timer <= r_timer + 32'd1;
      if (i_wr_cmp)    r_cmp   <= lane_merge(r_cmp, i_wdata, i_wen);
      if (i_wr_ctrl && i_wen[0]) begin
        r_run    <= i_wdata[CTRL_RUN];
        r_irq_en <= i_wdata[CTRL_IRQ_EN];
      end
      // A match in the same cycle as a W1C clear keeps the flag set.
      if (w_hit)      r_pend <= 1'b1;
      else if (w_clr) r_pend <= 1'b0;
    end
  end

  assign o_timer = r_timer;
  assign o_cmp   = r_cmp;
  assign o_ctrl  = {r_pend, r_irq_en, r_run};
  assign o_irq   = r_pend & r_irq_en;

endmodule

// File: rtl/confreg_resp.sv
// Peripheral-window responder: address decode, 1-cycle registered read data,
// LED/NUM registers, switch readback and a byte TX register with valid/ready.
module confreg_resp
  import confreg_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h1FAF_0000,
  parameter logic [31:0] SIMU_FLAG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_num;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic        w_in_win;
  logic        w_rd;
  logic        w_wr;
  logic [15:0] w_off;
  logic [31:0] w_rd_val;
  logic [31:0] w_timer;
  logic [31:0] w_cmp;
  logic [2:0]  w_ctrl;
  logic        w_unused;

  assign w_in_win = (addr[31:16] == BASE[31:16]);
  assign w_off    = {addr[15:2], 2'b00};
  assign w_rd     = en && (wen == 4'b0000);
  assign w_wr     = en && (wen != 4'b0000) && w_in_win;
  assign w_unused = &{1'b0, addr[1:0]};

  confreg_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_timer (w_wr && (w_off == OFF_TIMER)),
    .i_wr_cmp   (w_wr && (w_off == OFF_CMP)),
    .i_wr_ctrl  (w_wr && (w_off == OFF_CTRL)),
    .i_wen      (wen),
    .i_wdata    (wdata),
    .o_timer    (w_timer),
    .o_cmp      (w_cmp),
    .o_ctrl     (w_ctrl),
    .o_irq      (irq)
  );

  // NOTE: default assigned first so no path through this block can infer a latch.
  always_comb begin
    w_rd_val = 32'h0;
    if (w_in_win) begin
      case (w_off)
        OFF_TIMER:   w_rd_val = w_timer;
        OFF_CMP:     w_rd_val = w_cmp;
        OFF_CTRL:    w_rd_val = {29'h0, w_ctrl};
        OFF_LED:     w_rd_val = {16'h0, r_led};
        OFF_NUM:     w_rd_val = r_num;
        OFF_SWITCH:  w_rd_val = {24'h0, switch_in};
        OFF_UART_ST: w_rd_val = {31'h0, r_tx_valid};
        OFF_SIMU:    w_rd_val = SIMU_FLAG;
        default:     w_rd_val = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= 32'h0;
      r_led      <= 16'h0;
      r_num      <= 32'h0;
      r_tx_data  <= 8'h0;
      r_tx_valid <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rd_val;
      if (w_wr && (w_off == OFF_LED)) begin
        if (wen[0]) r_led[7:0]  <= wdata[7:0];
        if (wen[1]) r_led[15:8] <= wdata[15:8];
      end
      if (w_wr && (w_off == OFF_NUM)) r_num <= lane_merge(r_num, wdata, wen);
      // While a byte is pending, new writes are dropped, including in the handshake cycle.
      if (r_tx_valid) begin
        if (tx_ready) r_tx_valid <= 1'b0;
      end else if (w_wr && (w_off == OFF_UART_TX) && wen[0]) begin
        r_tx_data  <= wdata[7:0];
        r_tx_valid <= 1'b1;
      end
    end
  end

  assign rdata    = r_rdata;
  assign led      = r_led;
  assign num      = r_num;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_confreg_resp.sv
// Directed bench for confreg_resp: table of bus accesses with expected read data,
// plus hand-written timer, interrupt race, UART handshake and reset sequences.
module tb_confreg_resp;
  import confreg_pkg::*;

  localparam logic [31:0] B = 32'h1FAF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;

  confreg_resp #(.BASE(B), .SIMU_FLAG(32'h0000_0001)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .switch_in (switch_in),
    .led       (led),
    .num       (num),
    .irq       (irq),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ra(input logic [15:0] off);
    return B | {16'h0, off};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    en = 1'b1; wen = w; addr = a; wdata = d;
    tick();
    en = 1'b0; wen = 4'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    en = 1'b1; wen = 4'b0; addr = a;
    tick();
    en = 1'b0;
    d = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; en = 1'b0; wen = 4'b0; addr = 32'h0; wdata = 32'h0;
    switch_in = 8'hA5; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);

    vecs.push_back('{1'b1, ra(OFF_NUM),    4'hF, 32'h1234_5678, 32'h0, "w_num"});
    vecs.push_back('{1'b1, ra(OFF_NUM),    4'h5, 32'hAABB_CCDD, 32'h0, "w_num_lanes"});
    vecs.push_back('{1'b0, ra(OFF_NUM),    4'h0, 32'h0, 32'h12BB_56DD, "num_lanes"});
    vecs.push_back('{1'b0, ra(OFF_SWITCH), 4'h0, 32'h0, 32'h0000_00A5, "switch"});
    vecs.push_back('{1'b1, ra(OFF_SWITCH), 4'hF, 32'hFFFF_FFFF, 32'h0, "w_switch"});
    vecs.push_back('{1'b0, ra(OFF_SWITCH), 4'h0, 32'h0, 32'h0000_00A5, "switch_ro"});
    vecs.push_back('{1'b0, 32'h1FAF_0010,  4'h0, 32'h0, 32'h0, "unmapped"});
    vecs.push_back('{1'b0, 32'h1FAE_F000,  4'h0, 32'h0, 32'h0, "out_of_window"});
    vecs.push_back('{1'b1, ra(OFF_LED),    4'hF, 32'hFFFF_ABCD, 32'h0, "w_led"});
    vecs.push_back('{1'b0, ra(OFF_LED),    4'h0, 32'h0, 32'h0000_ABCD, "led"});
    vecs.push_back('{1'b1, ra(OFF_LED),    4'h2, 32'h0000_1200, 32'h0, "w_led_lane1"});
    vecs.push_back('{1'b0, B | 32'hF001,   4'h0, 32'h0, 32'h0000_12CD, "led_lane_addrlo"});
    vecs.push_back('{1'b0, ra(OFF_SIMU),   4'h0, 32'h0, 32'h0000_0001, "simu"});
    vecs.push_back('{1'b0, ra(OFF_UART_ST),4'h0, 32'h0, 32'h0, "uart_st_idle"});
    vecs.push_back('{1'b0, ra(OFF_CMP),    4'h0, 32'h0, 32'hFFFF_FFFF, "cmp_rst"});
    vecs.push_back('{1'b0, ra(OFF_CTRL),   4'h0, 32'h0, 32'h0, "ctrl_rst"});
    vecs.push_back('{1'b1, 32'h1FAE_F000,  4'hF, 32'hDEAD_BEEF, 32'h0, "w_oow"});
    vecs.push_back('{1'b0, ra(OFF_LED),    4'h0, 32'h0, 32'h0000_12CD, "oow_write"});

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d, vecs[i].w);
      else begin
        rd(vecs[i].a, v);
        check(vecs[i].name, v, vecs[i].exp);
      end
    end
    check("num_out", num, 32'h12BB_56DD);
    check("led_out", {16'h0, led}, 32'h0000_12CD);

    // rdata holds through idle cycles and writes
    tick();
    check("rdata_hold_idle", rdata, 32'h0000_12CD);
    wr(ra(OFF_NUM), 32'h0, 4'hF);
    check("rdata_hold_wr", rdata, 32'h0000_12CD);

    // Timer: TIMER=5, CMP=8, CTRL=3 -> irq rises 4 cycles after the CTRL write
    wr(ra(OFF_TIMER), 32'd5, 4'hF);
    wr(ra(OFF_CMP), 32'd8, 4'hF);
    wr(ra(OFF_CTRL), 32'd3, 4'h1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("irq_cycle%0d", c), {31'h0, irq}, (c == 4) ? 32'h1 : 32'h0);
    end
    wr(ra(OFF_CTRL), 32'd6, 4'h1);
    check("irq_w1c", {31'h0, irq}, 32'h0);

    // Wrap: FFFF_FFFE -> FFFF_FFFF (match) -> 0 with pend set
    wr(ra(OFF_TIMER), 32'hFFFF_FFFE, 4'hF);
    wr(ra(OFF_CMP), 32'hFFFF_FFFF, 4'hF);
    wr(ra(OFF_CTRL), 32'd3, 4'h1);
    tick(); tick();
    check("irq_wrap", {31'h0, irq}, 32'h1);
    rd(ra(OFF_TIMER), v);
    check("timer_wrap", v, 32'h0);

    // Set/clear race: W1C issued in the cycle timer==cmp keeps pend
    wr(ra(OFF_CTRL), 32'd4, 4'h1);
    rd(ra(OFF_CTRL), v);
    check("ctrl_cleared", v, 32'h0);
    wr(ra(OFF_TIMER), 32'd20, 4'hF);
    wr(ra(OFF_CMP), 32'd22, 4'hF);
    wr(ra(OFF_CTRL), 32'd3, 4'h1);
    tick(); tick();
    wr(ra(OFF_CTRL), 32'd7, 4'h1);
    check("race_irq", {31'h0, irq}, 32'h1);
    rd(ra(OFF_CTRL), v);
    check("race_ctrl", v, 32'h7);
    wr(ra(OFF_CTRL), 32'd7, 4'h1);
    check("race_then_clear", {31'h0, irq}, 32'h0);

    // UART: second write while busy dropped, data held, handshake clears valid
    wr(ra(OFF_UART_TX), 32'h0000_0041, 4'h1);
    check("tx_valid_set", {31'h0, tx_valid}, 32'h1);
    wr(ra(OFF_UART_TX), 32'h0000_0042, 4'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("tx_data_held", {24'h0, tx_data}, 32'h41);
    end
    rd(ra(OFF_UART_ST), v);
    check("uart_st_busy", v, 32'h1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("tx_valid_clr", {31'h0, tx_valid}, 32'h0);
    rd(ra(OFF_UART_ST), v);
    check("uart_st_done", v, 32'h0);
    wr(ra(OFF_UART_TX), 32'h0000_0050, 4'h1);
    check("tx_data_50", {24'h0, tx_data}, 32'h50);
    tx_ready = 1'b1;
    wr(ra(OFF_UART_TX), 32'h0000_0051, 4'h1);
    tx_ready = 1'b0;
    check("tx_drop_in_handshake", {31'h0, tx_valid}, 32'h0);

    // Reset mid-access: read of LED during the reset cycle
    wr(ra(OFF_LED), 32'h0000_BEEF, 4'h3);
    wr(ra(OFF_CTRL), 32'h0000_0001, 4'h1);
    en = 1'b1; wen = 4'b0; addr = ra(OFF_LED); rst = 1'b1;
    tick();
    en = 1'b0; rst = 1'b0;
    check("rst2_rdata", rdata, 32'h0);
    check("rst2_led", {16'h0, led}, 32'h0);
    check("rst2_num", num, 32'h0);
    check("rst2_irq", {31'h0, irq}, 32'h0);
    check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst2_tx_data", {24'h0, tx_data}, 32'h0);
    rd(ra(OFF_CMP), v);
    check("rst2_cmp", v, 32'hFFFF_FFFF);
    rd(ra(OFF_TIMER), v);
    check("rst2_timer", v, 32'h0);
    rd(ra(OFF_CTRL), v);
    check("rst2_ctrl", v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
